// File: rtl/reaction_timer.sv
// Reaction timer: randomized wait, GO light, millisecond reaction measurement.
// Detects false starts and saturates the measured time at 9999 ms.
module reaction_timer #(
    parameter int TICK_DIV   = 50000,
    parameter int BASE_DELAY = 1000
) (
    input  logic        CLK1,
    input  logic        RESET,
    input  logic        START,
    input  logic        STOP,
    input  logic [7:0]  RandIn,
    output logic        LedGo,
    output logic [13:0] ReactTime,
    output logic        Valid,
    output logic        FalseStart,
    output logic        Busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);
    localparam logic [13:0] RT_MAX = 14'd9999;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ARMED = 3'd2,
        S_DONE  = 3'd3,
        S_FALSE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [11:0]   dcnt_q, dcnt_d;
    logic [11:0]   delay_q, delay_d;
    logic [13:0]   rcnt_q, rcnt_d;
    logic [13:0]   rt_q, rt_d;

    logic [1:0] start_sync_q, stop_sync_q;
    logic       start_prev_q, stop_prev_q;
    logic [1:0] prime_q;

    logic        start_evt, stop_evt;
    logic        tick;
    logic [13:0] rcnt_inc;

    // Synchronize the buttons and keep a delayed copy for edge detection;
    // prime_q masks the bogus edge of a button already held at reset release.
    always_ff @(posedge CLK1 or posedge RESET) begin
        if (RESET) begin
            start_sync_q <= 2'b00;
            stop_sync_q  <= 2'b00;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            prime_q      <= 2'd0;
        end else begin
            start_sync_q <= {start_sync_q[0], START};
            stop_sync_q  <= {stop_sync_q[0], STOP};
            start_prev_q <= start_sync_q[1];
            stop_prev_q  <= stop_sync_q[1];
            if (prime_q != 2'd3) begin
                prime_q <= prime_q + 2'd1;
            end
        end
    end

    assign start_evt = (prime_q == 2'd3) && start_sync_q[1] && !start_prev_q;
    assign stop_evt  = (prime_q == 2'd3) && stop_sync_q[1] && !stop_prev_q;

    assign tick     = (presc_q == PS_MAX);
    assign rcnt_inc = (tick && rcnt_q != RT_MAX) ? rcnt_q + 14'd1 : rcnt_q;

    // Next-state logic for the trial sequencer and its counters
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        delay_d = delay_q;
        rcnt_d  = rcnt_q;
        rt_d    = rt_q;
        case (state_q)
            S_IDLE, S_DONE, S_FALSE: begin
                if (start_evt) begin
                    state_d = S_WAIT;
                    delay_d = 12'(BASE_DELAY) + 12'({RandIn, 2'b00});
                    dcnt_d  = 12'd0;
                end
            end
            S_WAIT: begin
                if (stop_evt) begin
                    state_d = S_FALSE;
                end else if (tick) begin
                    dcnt_d = dcnt_q + 12'd1;
                    if (dcnt_q == delay_q - 12'd1) begin
                        state_d = S_ARMED;
                        rcnt_d  = 14'd0;
                    end
                end
            end
            S_ARMED: begin
                if (stop_evt) begin
                    state_d = S_DONE;
                    rt_d    = rcnt_inc;
                end else begin
                    rcnt_d = rcnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The ms prescaler restarts on every state change so intervals are exact
    always_comb begin
        if (state_d != state_q || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // State and datapath registers
    always_ff @(posedge CLK1 or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            dcnt_q  <= 12'd0;
            delay_q <= 12'd0;
            rcnt_q  <= 14'd0;
            rt_q    <= 14'd0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            dcnt_q  <= dcnt_d;
            delay_q <= delay_d;
            rcnt_q  <= rcnt_d;
            rt_q    <= rt_d;
        end
    end

    assign LedGo      = (state_q == S_ARMED);
    assign Valid      = (state_q == S_DONE);
    assign FalseStart = (state_q == S_FALSE);
    assign Busy       = (state_q == S_WAIT) || (state_q == S_ARMED);
    assign ReactTime  = rt_q;

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter TICK_DIV, default 50000, SHALL set the clock cycles per 1 ms tick (50 MHz CLK1).
REQ-002 Parameter BASE_DELAY, default 1000, SHALL set the fixed part of the random delay, in ticks.
REQ-003 CLK1  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 RESET  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 START  input  1  SHALL be the raw start button level (active-high, asynchronous to CLK1).
REQ-006 STOP  input  1  SHALL be the raw player response button level (active-high, asynchronous).
REQ-007 RandIn  input  8  SHALL be the upstream LFSR value, sampled only on a start event.
REQ-008 LedGo  output  1  SHALL be high only in state ARMED.
REQ-009 ReactTime  output  14  SHALL be the measured reaction time in ms, binary, saturating at 9999.
REQ-010 Valid  output  1  SHALL be high only in state DONE.
REQ-011 FalseStart  output  1  SHALL be high only in state FALSE_START.
REQ-012 Busy  output  1  SHALL be high in states WAIT and ARMED.

Function
REQ-013 START and STOP SHALL each pass through a 2-flop synchronizer and a rising-edge detector, giving a one-cycle internal event.
REQ-014 The block SHALL act on an event at the 3rd CLK1 rising edge after the raw input rises. Holding an input high SHALL give only one event.
REQ-015 A prescaler SHALL count 0..TICK_DIV-1 and pulse tick for one cycle when it equals TICK_DIV-1.
REQ-016 The prescaler SHALL clear to 0 on every state transition.
REQ-017 The states SHALL be IDLE, WAIT, ARMED, DONE and FALSE_START, encoded in 3 bits. Unused encodings SHALL go to IDLE on the next edge.
REQ-018 IDLE + start event -> WAIT:
  - latch delay = BASE_DELAY + 4*RandIn, a 12-bit unsigned value;
  - clear the delay counter.
  RandIn = 0 SHALL be legal and give delay = BASE_DELAY.
REQ-019 In IDLE, a stop event SHALL be ignored.
REQ-020 WAIT: each tick SHALL increment the delay counter. When the counter reaches delay-1 on a tick, the state SHALL go to ARMED and the reaction counter SHALL clear.
REQ-021 WAIT + stop event -> FALSE_START. ReactTime SHALL be unchanged.
REQ-022 ARMED: each tick SHALL increment the reaction counter, which SHALL hold at 9999.
REQ-023 ARMED + stop event -> DONE. ReactTime SHALL load the reaction counter value, including a tick in that same cycle.
REQ-024 In WAIT and ARMED, a start event SHALL be ignored.
REQ-025 DONE or FALSE_START + start event SHALL behave exactly as REQ-018. ReactTime SHALL hold until the next DONE.
REQ-026 Start and stop events in the same cycle: IDLE/DONE/FALSE_START SHALL take START; WAIT/ARMED SHALL take STOP.
REQ-027 The WAIT->ARMED tick and a stop event in the same cycle SHALL give FALSE_START.
REQ-028 All outputs SHALL be registered or decoded directly from the state register. There SHALL be no combinational path from any input to any output.

Reset
REQ-029 RESET high SHALL immediately set:
  - state = IDLE;
  - prescaler, delay counter, reaction counter and latched delay = 0;
  - synchronizer and edge flops = 0;
  - ReactTime = 0, LedGo = 0, Valid = 0, FalseStart = 0, Busy = 0.
REQ-030 RESET during WAIT or ARMED SHALL abort the operation. After release, only a new start event SHALL begin a trial.
REQ-031 An input held high across RESET release SHALL NOT generate an event.

Verification (TICK_DIV=4, BASE_DELAY=8)
REQ-032 Reset, RandIn=8'h02, START pulse -> Busy high 3 cycles after START rises. LedGo rises after exactly 16 ticks (64 cycles) in WAIT.
REQ-033 Continue: STOP 5 ticks after LedGo -> Valid=1, ReactTime=5, LedGo=0, Busy=0.
REQ-034 Fresh trial, STOP during WAIT -> FalseStart=1, LedGo never rises, ReactTime keeps its previous value.
REQ-035 ARMED, STOP withheld for 10000+ ticks -> ReactTime=9999 on STOP, with no wrap.
REQ-036 START and STOP raised in the same cycle from IDLE -> WAIT entered. STOP held high produces no later event.
REQ-037 RESET asserted mid-ARMED -> all outputs 0 asynchronously. State stays IDLE after release while START remains high.
